pipe_hazard_ctrl: RTL and testbench

Central sequencer for the five-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It generates per-stage load enables and bubble/flush controls for three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses in MEM. It also flushes the pipeline after reset, traps a memory timeout, and keeps stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 14 +
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [1:0]  WB_BUBBLE = 2'b00;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the datapath and per-stage register controls back to it.
interface pipe_hazard_ctrl_if;

  logic       id_ex_mem_read;
  logic [4:0] id_ex_rt;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ready;

  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       mem_wb_bubble;

  // master: the sequencer; slave: the pipeline datapath
  modport master (
    input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
           branch_taken, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_bubble, mem_wb_bubble
  );

  modport slave (
    output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
           branch_taken, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_bubble, mem_wb_bubble
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_detect (
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  output logic       load_use
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = id_ex_mem_read & (id_ex_rt != 5'd0) &
                    ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: stage enables, bubbles/flushes, memory timeout trap
// and stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.master hif,
  output logic               bus_error,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(MEM_TIMEOUT);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               bus_error_q, bus_error_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               load_use;
  logic               freeze;
  logic [WAIT_W:0]    wait_inc;
  logic [7:0]         ctrl;

  hazard_detect u_hazard_detect (
    .id_ex_mem_read (hif.id_ex_mem_read),
    .id_ex_rt       (hif.id_ex_rt),
    .if_id_rs       (hif.if_id_rs),
    .if_id_rt       (hif.if_id_rt),
    .load_use       (load_use)
  );

  assign freeze   = hif.dmem_req & ~hif.dmem_ready;
  assign wait_inc = {1'b0, wait_cnt_q} + 1'b1;

  // ctrl = {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_bubble, mem_wb_bubble}
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    bus_error_d = bus_error_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ctrl        = 8'b00000_000;
    case (state_q)
      ST_INIT: begin
        ctrl    = 8'b00000_111;
        state_d = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (freeze) begin
          // Only MEM/WB advances, and it takes a bubble while MEM is held
          ctrl        = 8'b00001_001;
          stall_cnt_d = stall_cnt_q + 1'b1;
          wait_cnt_d  = wait_inc[WAIT_W-1:0];
          if (wait_inc >= TIMEOUT_V) begin
            state_d     = ST_ERROR;
            bus_error_d = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end else begin
          wait_cnt_d = '0;
          state_d    = ST_RUN;
          if (hif.branch_taken) begin
            ctrl        = 8'b11111_110;
            flush_cnt_d = flush_cnt_q + 1'b1;
          end else if (load_use) begin
            ctrl        = 8'b00111_010;
            stall_cnt_d = stall_cnt_q + 1'b1;
          end else begin
            ctrl = 8'b11111_000;
          end
        end
      end
      ST_ERROR: begin
        ctrl = 8'b00000_111;
      end
      default: begin
        ctrl    = 8'b00000_111;
        state_d = ST_INIT;
      end
    endcase
  end

  assign hif.pc_en         = ctrl[7];
  assign hif.if_id_en      = ctrl[6];
  assign hif.id_ex_en      = ctrl[5];
  assign hif.ex_mem_en     = ctrl[4];
  assign hif.mem_wb_en     = ctrl[3];
  assign hif.if_id_flush   = ctrl[2];
  assign hif.id_ex_bubble  = ctrl[1];
  assign hif.mem_wb_bubble = ctrl[0];

  assign bus_error = bus_error_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected controls are queued as each step is
// driven and popped when the outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] C_NORM   = 8'b11111_000;
  localparam logic [7:0] C_INIT   = 8'b00000_111;
  localparam logic [7:0] C_FREEZE = 8'b00001_001;
  localparam logic [7:0] C_BRANCH = 8'b11111_110;
  localparam logic [7:0] C_LU     = 8'b00111_010;

  typedef struct packed {
    logic [7:0] ctrl;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_error;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  pipe_hazard_ctrl_if hif ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hif       (hif),
    .bus_error (bus_error),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  wire [7:0] ctrl_obs = {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en, hif.mem_wb_en,
                         hif.if_id_flush, hif.id_ex_bubble, hif.mem_wb_bubble};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic bt, input logic req, input logic rdy);
    hif.id_ex_mem_read = mr;
    hif.id_ex_rt       = ert;
    hif.if_id_rs       = rs;
    hif.if_id_rt       = rt;
    hif.branch_taken   = bt;
    hif.dmem_req       = req;
    hif.dmem_ready     = rdy;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    $display("[%0t] %-10s ctrl=%b bus_error=%b stall=%0d flush=%0d",
             $time, tag, ctrl_obs, bus_error, stall_cnt, flush_cnt);
    chk({tag, ".ctrl"}, 64'(ctrl_obs), 64'(e.ctrl));
    chk({tag, ".err"}, 64'(bus_error), 64'(e.err));
  endtask

  // One pipeline cycle: drive just after the rising edge, compare at the falling edge.
  task automatic step(input string tag, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic bt,
                      input logic req, input logic rdy,
                      input logic [7:0] exp_ctrl, input logic exp_err);
    @(posedge clk);
    #1;
    drive(mr, ert, rs, rt, bt, req, rdy);
    sb_q.push_back('{ctrl: exp_ctrl, err: exp_err});
    @(negedge clk);
    compare_out(tag);
  endtask

  task automatic chk_cnt(input string tag, input int exp_stall, input int exp_flush);
    chk({tag, ".stall"}, 64'(stall_cnt), 64'(exp_stall));
    chk({tag, ".flush"}, 64'(flush_cnt), 64'(exp_flush));
  endtask

  initial begin
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Held in reset: INIT outputs, registered state cleared
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back('{ctrl: C_INIT, err: 1'b0});
    compare_out("in_reset");
    chk_cnt("in_reset", 0, 0);

    // Release mid-cycle: this remainder is cycle 0 (INIT), next edge enters RUN
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sb_q.push_back('{ctrl: C_INIT, err: 1'b0});
    compare_out("cycle0");
    step("cycle1", 0, 0, 0, 0, 0, 0, 0, C_NORM, 0);
    chk_cnt("cycle1", 0, 0);

    // Load-use: exactly one bubble cycle
    step("lu",       1, 5'd8, 5'd8, 5'd3, 0, 0, 0, C_LU,   0);
    step("lu_after", 0, 5'd8, 5'd9, 5'd3, 0, 0, 0, C_NORM, 0);
    chk_cnt("lu_after", 1, 0);
    step("lu_rt_match", 1, 5'd7, 5'd2, 5'd7, 0, 0, 0, C_LU, 0);
    step("lu_r0",    1, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NORM, 0);
    chk_cnt("lu_r0", 2, 0);

    // Branch wins over a wrong-path load-use
    step("br_lu",    1, 5'd8, 5'd8, 5'd0, 1, 0, 0, C_BRANCH, 0);
    step("br_after", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NORM,   0);
    chk_cnt("br_after", 2, 1);

    // Slow memory: three frozen cycles; branch during the wait is held off
    step("mem_w1", 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0);
    step("mem_w2", 0, 0, 0, 0, 1, 1, 0, C_FREEZE, 0);
    step("mem_w3", 1, 5'd4, 5'd4, 0, 1, 1, 0, C_FREEZE, 0);
    step("mem_rel", 1, 5'd4, 5'd4, 0, 1, 1, 1, C_BRANCH, 0);
    chk_cnt("mem_rel", 5, 1);
    step("mem_post", 0, 0, 0, 0, 0, 0, 0, C_NORM, 0);
    chk_cnt("mem_post", 5, 2);

    // Aborted access, then a 15-cycle wait that must not trip the timeout
    step("abort_w1", 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0);
    step("abort_w2", 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0);
    step("abort",    0, 0, 0, 0, 0, 0, 0, C_NORM,   0);
    for (int i = 0; i < 15; i++)
      step($sformatf("long_w%0d", i + 1), 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0);
    step("long_rel", 0, 0, 0, 0, 0, 1, 1, C_NORM, 0);
    chk_cnt("long_rel", 22, 2);

    // Timeout: 16 frozen cycles, trap from cycle 17
    for (int i = 0; i < 16; i++)
      step($sformatf("to_w%0d", i + 1), 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0);
    step("to_err",  0, 0, 0, 0, 0, 1, 0, C_INIT, 1);
    chk_cnt("to_err", 38, 2);
    step("to_hold", 0, 0, 0, 0, 1, 1, 1, C_INIT, 1);
    chk_cnt("to_hold", 38, 2);

    // Asynchronous reset out of ERROR, away from any clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.push_back('{ctrl: C_INIT, err: 1'b0});
    compare_out("async_rst");
    chk_cnt("async_rst", 0, 0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_run", 0, 0, 0, 0, 0, 0, 0, C_NORM, 0);
    chk_cnt("rst_run", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
